// File: rtl/oscope_pkg.sv
// ============================================================================
// Package  : oscope_pkg
// Brief    : Shared widths, transmitter state encoding and the sync byte
//            used by the capture-buffer readout path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package oscope_pkg;

    // Default buffer address and sample widths
    localparam int c_ADDR_W = 10;
    localparam int c_DATA_W = 8;

    // Constant byte sent ahead of the payload when the header is enabled
    localparam logic [7:0] c_SYNC_BYTE = 8'hA5;

    // Transmitter state encoding
    typedef logic [2:0] tx_state_t;
    localparam tx_state_t c_IDLE  = 3'd0;
    localparam tx_state_t c_FETCH = 3'd1;
    localparam tx_state_t c_LOAD  = 3'd2;
    localparam tx_state_t c_SHIFT = 3'd3;
    localparam tx_state_t c_DONE  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// ============================================================================
// Module   : sync_edge
// Brief    : Multi-flop synchroniser for an asynchronous level, with
//            one-cycle rise/fall pulses from the last two synchronised samples.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the async input through the chain and keep the previous sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  =  o_level & ~r_prev;
    assign o_fall  = ~o_level &  r_prev;

endmodule

`default_nettype wire

// File: rtl/pi_buf_tx.sv
// ============================================================================
// Module   : pi_buf_tx
// Brief    : Reads a full capture buffer from RAM and serialises it MSB-first
//            to the Pi, stepping one bit per synchronised pi_clk fall. Hands
//            the buffer back via capture_restart on completion or pi_done.
// Options  : PI_TX_HEADER_EN - send sync byte 8'hA5 before the payload
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pi_buf_tx
    import oscope_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = c_ADDR_W,
    parameter int DATA_W      = c_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              osc_clk,
    input  logic              reset,
    input  logic              buf_full,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_adr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              pi_clk,
    input  logic              pi_done,
    output logic              pi_signal_flag,
    output logic              pi_data,
    output logic              capture_restart
);

    localparam int c_BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int c_CNT_W = ADDR_W + 1;
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0]  c_ADR_LAST = ADDR_W'(DEPTH - 1);
`ifdef PI_TX_HEADER_EN
    // One extra byte on the wire: the sync byte precedes address 0
    localparam logic [c_CNT_W-1:0] c_BYTE_LAST  = c_CNT_W'(DEPTH);
    localparam logic [DATA_W-1:0]  c_FIRST_BYTE = DATA_W'(c_SYNC_BYTE);
`else
    localparam logic [c_CNT_W-1:0] c_BYTE_LAST  = c_CNT_W'(DEPTH - 1);
`endif

    tx_state_t          r_state;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  r_pf;
    logic               r_rd_en_d;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [c_CNT_W-1:0] r_byte_cnt;
    logic               r_armed;

    logic w_pi_level;
    logic w_pi_rise;
    logic w_pi_fall;
    logic w_done;
    logic w_done_rise;
    logic w_done_fall;
    logic w_unused;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pi_clk (
        .clk     (osc_clk),
        .rst     (reset),
        .i_async (pi_clk),
        .o_level (w_pi_level),
        .o_rise  (w_pi_rise),
        .o_fall  (w_pi_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pi_done (
        .clk     (osc_clk),
        .rst     (reset),
        .i_async (pi_done),
        .o_level (w_done),
        .o_rise  (w_done_rise),
        .o_fall  (w_done_fall)
    );

    // Only the pi_clk fall and the pi_done level drive the transmitter
    assign w_unused = &{1'b0, w_pi_level, w_pi_rise, w_done_rise, w_done_fall};

    // The serial line is always the MSB of the shift register; clearing the
    // register in reset/DONE therefore also parks pi_data low
    assign pi_data = r_shift[DATA_W-1];

    // Capture read data one cycle after every read strobe
    always_ff @(posedge osc_clk) begin
        if (reset) begin
            r_rd_en_d <= 1'b0;
            r_pf      <= '0;
        end else begin
            r_rd_en_d <= rd_en;
            if (r_rd_en_d) begin
                r_pf <= rd_data;
            end
        end
    end

    // Transfer sequencer: fetch, load, shift per pi_clk fall, hand back
    always_ff @(posedge osc_clk) begin
        if (reset) begin
            r_state         <= c_IDLE;
            r_shift         <= '0;
            r_bit_cnt       <= '0;
            r_byte_cnt      <= '0;
            r_armed         <= 1'b1;
            rd_en           <= 1'b0;
            rd_adr          <= '0;
            pi_signal_flag  <= 1'b0;
            capture_restart <= 1'b0;
        end else begin
            rd_en           <= 1'b0;
            capture_restart <= 1'b0;
            if (!buf_full) begin
                r_armed <= 1'b1;
            end

            case (r_state)
                c_IDLE: begin
                    if (buf_full && r_armed) begin
                        rd_en   <= 1'b1;
                        rd_adr  <= '0;
                        r_state <= c_FETCH;
                    end
                end

                c_FETCH: begin
                    r_state <= w_done ? c_DONE : c_LOAD;
                end

                c_LOAD: begin
                    if (w_done) begin
                        r_state <= c_DONE;
                    end else begin
`ifdef PI_TX_HEADER_EN
                        // Address-0 data lands in the prefetch register this
                        // cycle; the next prefetch waits for the first boundary
                        r_shift <= c_FIRST_BYTE;
`else
                        r_shift <= rd_data;
                        if (rd_adr != c_ADR_LAST) begin
                            rd_en  <= 1'b1;
                            rd_adr <= rd_adr + 1'b1;
                        end
`endif
                        pi_signal_flag <= 1'b1;
                        r_bit_cnt      <= '0;
                        r_state        <= c_SHIFT;
                    end
                end

                c_SHIFT: begin
                    if (w_done) begin
                        r_state <= c_DONE;
                    end else if (w_pi_fall) begin
                        if (r_bit_cnt != c_BIT_LAST) begin
                            r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end else if (r_byte_cnt < c_BYTE_LAST) begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                            r_shift    <= r_pf;
                            r_bit_cnt  <= '0;
                            if (rd_adr != c_ADR_LAST) begin
                                rd_en  <= 1'b1;
                                rd_adr <= rd_adr + 1'b1;
                            end
                        end else begin
                            r_state <= c_DONE;
                        end
                    end
                end

                c_DONE: begin
                    pi_signal_flag  <= 1'b0;
                    capture_restart <= 1'b1;
                    r_shift         <= '0;
                    r_bit_cnt       <= '0;
                    r_byte_cnt      <= '0;
                    rd_adr          <= '0;
                    // A buf_full still high from this buffer must drop first
                    r_armed         <= 1'b0;
                    r_state         <= c_IDLE;
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pi_buf_tx.sv
// ============================================================================
// Module   : tb_pi_buf_tx
// Brief    : Self-checking bench for pi_buf_tx: RAM model, Pi clocking model
//            with random phase lengths, byte-stream reference model.
// Options  : PI_TX_HEADER_EN - expects the 8'hA5 sync byte first
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pi_buf_tx;

    localparam int DEPTH       = 100;
    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;
`ifdef PI_TX_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int NBYTES = DEPTH + HDR;

    logic              osc_clk  = 1'b0;
    logic              reset    = 1'b1;
    logic              buf_full = 1'b0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_adr;
    logic [DATA_W-1:0] rd_data  = '0;
    logic              pi_clk   = 1'b0;
    logic              pi_done  = 1'b0;
    logic              pi_signal_flag;
    logic              pi_data;
    logic              capture_restart;

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    bit         rx_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int rd_cnt   = 0;
    int rst_cnt  = 0;
    int bad_adr  = 0;
    int last_rd  = 0;

    pi_buf_tx #(
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .osc_clk         (osc_clk),
        .reset           (reset),
        .buf_full        (buf_full),
        .rd_en           (rd_en),
        .rd_adr          (rd_adr),
        .rd_data         (rd_data),
        .pi_clk          (pi_clk),
        .pi_done         (pi_done),
        .pi_signal_flag  (pi_signal_flag),
        .pi_data         (pi_data),
        .capture_restart (capture_restart)
    );

    always #5 osc_clk = ~osc_clk;

    // Synchronous-read RAM and activity monitors
    always @(posedge osc_clk) begin
        if (rd_en === 1'b1) begin
            rd_data <= mem[rd_adr];
            rd_cnt  <= rd_cnt + 1;
            if (rd_adr > ADDR_W'(DEPTH - 1)) bad_adr <= bad_adr + 1;
            if (rd_adr == ADDR_W'(DEPTH - 1)) last_rd <= last_rd + 1;
        end
        if (capture_restart === 1'b1) rst_cnt <= rst_cnt + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: byte k of the wire stream
    function automatic logic [7:0] exp_byte(input int k);
        if (HDR == 1 && k == 0) return 8'hA5;
        return mem[k - HDR];
    endfunction

    // Byte b assembled MSB-first from the bits the Pi sampled
    function automatic logic [7:0] rx_byte(input int b);
        logic [7:0] v;
        v = '0;
        for (int j = 0; j < 8; j++)
            if (b * 8 + j < rx_q.size()) v[7-j] = rx_q[b*8+j];
        return v;
    endfunction

    task automatic fill_mem(input bit pattern);
        for (int i = 0; i < (1 << ADDR_W); i++)
            mem[i] = pattern ? 8'(i) : 8'($urandom);
    endtask

    task automatic trigger();
        buf_full = 1'b0;
        repeat (4) @(negedge osc_clk);
        buf_full = 1'b1;
    endtask

    task automatic wait_flag(input string name);
        int n;
        n = 0;
        while (pi_signal_flag !== 1'b1 && n < 50) begin
            @(negedge osc_clk);
            n++;
        end
        n_checks++;
        if (pi_signal_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL %s flag_rise: flag=%b after %0d cycles, required 1", name, pi_signal_flag, n);
        end
    endtask

    // Pi side: raise pi_clk and sample, then lower it, until flag drops
    task automatic pi_clock_bits(input int max_bits, input int fixed_phase);
        int ph;
        rx_q.delete();
        while (pi_signal_flag === 1'b1 && rx_q.size() < max_bits) begin
            pi_clk = 1'b1;
            rx_q.push_back(pi_data);
            ph = (fixed_phase > 0) ? fixed_phase : int'($urandom_range(12, 6));
            repeat (ph) @(negedge osc_clk);
            pi_clk = 1'b0;
            ph = (fixed_phase > 0) ? fixed_phase : int'($urandom_range(12, 6));
            repeat (ph) @(negedge osc_clk);
        end
    endtask

    task automatic abort_quiet(input string name);
        int n;
        pi_done = 1'b1;
        repeat (SYNC_STAGES + 4) @(negedge osc_clk);
        n = 0;
        while (pi_signal_flag !== 1'b0 && n < 50) begin
            @(negedge osc_clk);
            n++;
        end
        n_checks++;
        if (pi_signal_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL %s abort_flag: flag=%b, required 0", name, pi_signal_flag);
        end
        pi_done  = 1'b0;
        buf_full = 1'b0;
        repeat (10) @(negedge osc_clk);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        buf_full = 1'b0;
        repeat (3) @(negedge osc_clk);
        n_checks += 5;
        if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset rd_en: got %b want 0", rd_en); end
        if (rd_adr !== '0) begin n_fail++; $display("FAIL reset rd_adr: got %0h want 0", rd_adr); end
        if (pi_signal_flag !== 1'b0) begin n_fail++; $display("FAIL reset flag: got %b want 0", pi_signal_flag); end
        if (pi_data !== 1'b0) begin n_fail++; $display("FAIL reset pi_data: got %b want 0", pi_data); end
        if (capture_restart !== 1'b0) begin n_fail++; $display("FAIL reset restart: got %b want 0", capture_restart); end
        reset = 1'b0;
        repeat (3) @(negedge osc_clk);
    endtask

    task automatic test_msb_first();
        logic [7:0] got;
        fill_mem(1'b0);
        mem[0] = 8'hC3;
        trigger();
        wait_flag("msb_first");
        pi_clock_bits(8 * (HDR + 1), 0);
        for (int b = 0; b <= HDR; b++) begin
            got = rx_byte(b);
            n_checks++;
            if (got !== exp_byte(b)) begin
                n_fail++;
                $display("FAIL msb_first byte %0d: got %02h want %02h", b, got, exp_byte(b));
            end
        end
        got = rx_byte(HDR);
        n_checks++;
        if (got !== 8'hC3) begin
            n_fail++;
            $display("FAIL msb_first bits: got %08b want 11000011", got);
        end
        abort_quiet("msb_first");
    endtask

    task automatic test_abort();
        logic [7:0] got;
        logic [7:0] want;
        int r0, rd0, n;
        fill_mem(1'b0);
        r0 = rst_cnt;
        trigger();
        wait_flag("abort");
        pi_clock_bits(HDR * 8 + 28, 0);
        for (int b = 0; b < HDR + 3; b++) begin
            got  = rx_byte(b);
            want = exp_byte(b);
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL abort byte %0d: got %02h want %02h", b, got, want);
            end
        end
        got  = rx_byte(HDR + 3) & 8'hF0;
        want = exp_byte(HDR + 3) & 8'hF0;
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL abort partial: got %02h want %02h", got, want);
        end
        rd0     = rd_cnt;
        pi_done = 1'b1;
        n = 0;
        while (pi_signal_flag !== 1'b0 && n < 20) begin
            @(negedge osc_clk);
            n++;
        end
        n_checks++;
        if (pi_signal_flag !== 1'b0 || n > SYNC_STAGES + 2) begin
            n_fail++;
            $display("FAIL abort latency: flag=%b after %0d cycles, required 0 within %0d", pi_signal_flag, n, SYNC_STAGES + 2);
        end
        repeat (40) @(negedge osc_clk);
        n_checks += 3;
        if (rst_cnt - r0 != 1) begin n_fail++; $display("FAIL abort restart_count: got %0d want 1", rst_cnt - r0); end
        if (rd_cnt != rd0) begin n_fail++; $display("FAIL abort rd_after: got %0d reads want 0", rd_cnt - rd0); end
        if (pi_data !== 1'b0) begin n_fail++; $display("FAIL abort pi_data: got %b want 0", pi_data); end
        pi_done  = 1'b0;
        buf_full = 1'b0;
        repeat (10) @(negedge osc_clk);
    endtask

    task automatic test_full_readout(input bit pattern, input int phase);
        logic [7:0] got;
        logic [7:0] want;
        int r0, rd0, bad0, last0;
        fill_mem(pattern);
        r0 = rst_cnt; rd0 = rd_cnt; bad0 = bad_adr; last0 = last_rd;
        trigger();
        wait_flag("full_readout");
        pi_clock_bits(NBYTES * 8 + 16, phase);
        repeat (4) @(negedge osc_clk);
        n_checks++;
        if (rx_q.size() != NBYTES * 8) begin
            n_fail++;
            $display("FAIL full_readout bit_count: got %0d want %0d", rx_q.size(), NBYTES * 8);
        end
        for (int b = 0; b < NBYTES; b++) begin
            got  = rx_byte(b);
            want = exp_byte(b);
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL full_readout byte %0d: got %02h want %02h", b, got, want);
            end
        end
        n_checks += 5;
        if (pi_signal_flag !== 1'b0) begin n_fail++; $display("FAIL full_readout flag_end: got %b want 0", pi_signal_flag); end
        if (rst_cnt - r0 != 1) begin n_fail++; $display("FAIL full_readout restart_count: got %0d want 1", rst_cnt - r0); end
        if (rd_cnt - rd0 != DEPTH) begin n_fail++; $display("FAIL full_readout read_count: got %0d want %0d", rd_cnt - rd0, DEPTH); end
        if (bad_adr != bad0) begin n_fail++; $display("FAIL full_readout adr_range: got %0d out-of-range reads want 0", bad_adr - bad0); end
        if (last_rd - last0 != 1) begin n_fail++; $display("FAIL full_readout last_adr_reads: got %0d want 1", last_rd - last0); end
    endtask

    task automatic test_no_retrigger();
        int rd0, n;
        rd0 = rd_cnt;
        for (int t = 0; t < 6; t++) begin
            pi_clk = ~pi_clk;
            repeat (8) @(negedge osc_clk);
            n_checks++;
            if (pi_data !== 1'b0 || pi_signal_flag !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_toggle %0d: pi_data=%b flag=%b want 0/0", t, pi_data, pi_signal_flag);
            end
        end
        pi_clk = 1'b0;
        repeat (20) @(negedge osc_clk);
        n_checks++;
        if (rd_cnt != rd0) begin n_fail++; $display("FAIL no_retrigger reads: got %0d want 0", rd_cnt - rd0); end
        trigger();
        n = 0;
        while (rd_en !== 1'b1 && n < 20) begin
            @(negedge osc_clk);
            n++;
        end
        n_checks++;
        if (rd_en !== 1'b1 || rd_adr !== '0) begin
            n_fail++;
            $display("FAIL retrigger: rd_en=%b rd_adr=%0h, want 1/0", rd_en, rd_adr);
        end
        abort_quiet("retrigger");
    endtask

    task automatic test_reset_mid();
        logic [7:0] got;
        int r0, n;
        fill_mem(1'b0);
        trigger();
        wait_flag("reset_mid");
        pi_clock_bits(HDR * 8 + 43, 0);
        r0    = rst_cnt;
        reset = 1'b1;
        @(negedge osc_clk);
        n_checks += 5;
        if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_mid rd_en: got %b want 0", rd_en); end
        if (rd_adr !== '0) begin n_fail++; $display("FAIL reset_mid rd_adr: got %0h want 0", rd_adr); end
        if (pi_signal_flag !== 1'b0) begin n_fail++; $display("FAIL reset_mid flag: got %b want 0", pi_signal_flag); end
        if (pi_data !== 1'b0) begin n_fail++; $display("FAIL reset_mid pi_data: got %b want 0", pi_data); end
        if (capture_restart !== 1'b0) begin n_fail++; $display("FAIL reset_mid restart: got %b want 0", capture_restart); end
        repeat (3) @(negedge osc_clk);
        reset = 1'b0;
        n = 0;
        while (rd_en !== 1'b1 && n < 20) begin
            @(negedge osc_clk);
            n++;
        end
        n_checks += 2;
        if (rd_en !== 1'b1 || rd_adr !== '0) begin
            n_fail++;
            $display("FAIL reset_mid restart_adr: rd_en=%b rd_adr=%0h, want 1/0", rd_en, rd_adr);
        end
        if (rst_cnt != r0) begin n_fail++; $display("FAIL reset_mid no_restart: got %0d pulses want 0", rst_cnt - r0); end
        wait_flag("reset_mid_again");
        pi_clock_bits(8, 0);
        got = rx_byte(0);
        n_checks++;
        if (got !== exp_byte(0)) begin
            n_fail++;
            $display("FAIL reset_mid first_byte: got %02h want %02h", got, exp_byte(0));
        end
        abort_quiet("reset_mid");
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_abort();
        test_full_readout(1'b1, 12);
        test_no_retrigger();
        test_full_readout(1'b0, 0);
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
